// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 sizes, byte strobes, FSM states
// and the store lane-placement helpers.
package mem_pkg;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [3:0] StrbNone   = 4'b0000;
  localparam logic [3:0] StrbLoHalf = 4'b0011;
  localparam logic [3:0] StrbHiHalf = 4'b1100;
  localparam logic [3:0] StrbWord   = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } mem_state_e;

  function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3Byte:  store_strb = 4'b0001 << addr_lo;
      F3Half:  store_strb = addr_lo[1] ? StrbHiHalf : StrbLoHalf;
      default: store_strb = StrbWord;
    endcase
  endfunction

  // Narrow stores replicate the datum so every enabled lane carries it.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3Byte:  store_data = {4{data[7:0]}};
      F3Half:  store_data = {2{data[15:0]}};
      default: store_data = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-lane selection with sign/zero extension for B/H/BU/HU/W.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
    endcase
    // Halfword ignores addr[0]; misalignment is not trapped here.
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3Byte:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3Half:  data_o = {{16{half_sel[15]}}, half_sel};
      F3ByteU: data_o = {24'h0, byte_sel};
      F3HalfU: data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: issues loads/stores on a request/ready port, stalls upstream while an
// access is outstanding and produces the MEM/WB register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] result_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [2:0]        funct3_in,
  input  logic              wb_memtoreg_in,
  input  logic              wb_regwrite_in,
  input  logic              mem_memread_in,
  input  logic              mem_memwrite_in,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wstrb,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ready,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              wb_memtoreg_out,
  output logic              wb_regwrite_out
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        strb_q, strb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [REG_AW-1:0] rd_lat_q, rd_lat_d;
  logic              regwrite_lat_q, regwrite_lat_d;
  logic              memtoreg_lat_q, memtoreg_lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              memtoreg_q, memtoreg_d;
  logic              regwrite_q, regwrite_d;
  logic              stall_c;
  logic              access;
  logic [DATA_W-1:0] load_data;

  assign access = mem_memread_in | mem_memwrite_in;

  mem_load_align u_load_align (
    .rdata_i   (dm_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data)
  );

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    strb_d         = strb_q;
    wdata_d        = wdata_q;
    funct3_d       = funct3_q;
    addr_lo_d      = addr_lo_q;
    rd_lat_d       = rd_lat_q;
    regwrite_lat_d = regwrite_lat_q;
    memtoreg_lat_d = memtoreg_lat_q;
    rdata_d        = rdata_q;
    wb_data_d      = wb_data_q;
    alu_d          = result_in;
    rd_d           = rd_in;
    memtoreg_d     = wb_memtoreg_in;
    regwrite_d     = wb_regwrite_in;
    stall_c        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d        = StBusy;
          stall_c        = 1'b1;
          req_d          = 1'b1;
          we_d           = mem_memwrite_in;
          addr_d         = {result_in[ADDR_W-1:2], 2'b00};
          strb_d         = mem_memwrite_in ? store_strb(funct3_in, result_in[1:0]) : StrbNone;
          wdata_d        = mem_memwrite_in ? store_data(funct3_in, data2_in) : '0;
          funct3_d       = funct3_in;
          addr_lo_d      = result_in[1:0];
          rd_lat_d       = rd_in;
          regwrite_lat_d = wb_regwrite_in;
          memtoreg_lat_d = wb_memtoreg_in;
          regwrite_d     = 1'b0;
          memtoreg_d     = 1'b0;
        end
      end
      StBusy: begin
        stall_c    = 1'b1;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        if (dm_ready) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) rdata_d = load_data;
        end
      end
      StDone: begin
        state_d    = StIdle;
        rd_d       = rd_lat_q;
        regwrite_d = regwrite_lat_q;
        memtoreg_d = memtoreg_lat_q;
        if (!we_q) wb_data_d = rdata_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      strb_q         <= '0;
      wdata_q        <= '0;
      funct3_q       <= '0;
      addr_lo_q      <= '0;
      rd_lat_q       <= '0;
      regwrite_lat_q <= 1'b0;
      memtoreg_lat_q <= 1'b0;
      rdata_q        <= '0;
      wb_data_q      <= '0;
      alu_q          <= '0;
      rd_q           <= '0;
      memtoreg_q     <= 1'b0;
      regwrite_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      strb_q         <= strb_d;
      wdata_q        <= wdata_d;
      funct3_q       <= funct3_d;
      addr_lo_q      <= addr_lo_d;
      rd_lat_q       <= rd_lat_d;
      regwrite_lat_q <= regwrite_lat_d;
      memtoreg_lat_q <= memtoreg_lat_d;
      rdata_q        <= rdata_d;
      wb_data_q      <= wb_data_d;
      alu_q          <= alu_d;
      rd_q           <= rd_d;
      memtoreg_q     <= memtoreg_d;
      regwrite_q     <= regwrite_d;
    end
  end

  assign dm_req          = req_q;
  assign dm_we           = we_q;
  assign dm_addr         = addr_q;
  assign dm_wstrb        = strb_q;
  assign dm_wdata        = wdata_q;
  // Reset must release the upstream freeze even if access inputs are still asserted.
  assign mem_stall       = stall_c & ~rst;
  assign wb_data_out     = wb_data_q;
  assign alu_result_out  = alu_q;
  assign rd_out          = rd_q;
  assign wb_memtoreg_out = memtoreg_q;
  assign wb_regwrite_out = regwrite_q;

endmodule
